// File: rtl/ram_scan_port.sv
// Scan-read / user-write arbiter for a single-port 32x4 RAM (registered inputs, unregistered q).
// Define RAM_SCAN_BYPASS_EN to update the displayed word straight from write data instead of re-reading it.
module ram_scan_port #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) (
  input  logic              chosenClock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] scan_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] rd_addr_out,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              rd_valid,
  output logic              wr_busy
);

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] issue_addr;
  logic              rd_pend;
  logic              wr_pend;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              hit;

  assign hit       = (wr_addr_q == rd_addr_out);
  assign ram_wren  = (state == WR);
  assign ram_addr  = (state == WR) ? wr_addr_q : rd_addr_q;
  assign ram_wdata = (state == WR) ? wr_data_q : '0;
  assign wr_busy   = wr_pend | (state == WR);

  always_ff @(posedge chosenClock) begin
    if (reset) begin
      state       <= IDLE;
      last_addr   <= '0;
      rd_addr_q   <= '0;
      issue_addr  <= '0;
      rd_pend     <= 1'b1;
      wr_pend     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_out <= '0;
      rd_data_out <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid  <= 1'b0;
      last_addr <= scan_addr;

      case (state)
        IDLE: begin
          if (wr_pend) begin
            state <= WR;
          end else if (rd_pend) begin
            state   <= RD_ISSUE;
            rd_pend <= 1'b0;
          end
        end
        // A pending read follows the write directly so preemption costs one cycle only.
        WR: begin
          wr_pend <= 1'b0;
`ifdef RAM_SCAN_BYPASS_EN
          if (hit) begin
            rd_data_out <= wr_data_q;
            rd_valid    <= 1'b1;
          end
          if (rd_pend) begin
            state   <= RD_ISSUE;
            rd_pend <= 1'b0;
          end else begin
            state <= IDLE;
          end
`else
          if (rd_pend || hit) begin
            state   <= RD_ISSUE;
            rd_pend <= 1'b0;
          end else begin
            state <= IDLE;
          end
`endif
        end
        RD_ISSUE: begin
          issue_addr <= rd_addr_q;
          state      <= RD_WAIT;
        end
        // issue_addr keeps the displayed address paired with the word the RAM actually latched.
        RD_WAIT: begin
          rd_data_out <= ram_q;
          rd_addr_out <= issue_addr;
          rd_valid    <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (scan_addr != last_addr) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= scan_addr;
      end
      if (wr_req) begin
        wr_pend   <= 1'b1;
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
    end
  end

endmodule
